mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised up/down counter for the counter library. It generalises the fixed 4-bit enable counter with:
- configurable width and modulus;
- count direction, synchronous clear and parallel load;
- wrap or saturate mode;
- an enable prescaler, terminal-count and wrap outputs for cascading.

It is used standalone as a timer or event counter, or chained as BCD/decade stages.

## Interface
- WIDTH, 8, counter width in bits (1..32)
- MAX_VAL, 2**WIDTH-1, highest count value; elaboration error if MAX_VAL > 2**WIDTH-1 or MAX_VAL = 0
- PRESCALE, 1, number of enabled cycles per count step (1 = every enabled cycle)
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of count and prescaler
- enable  in  1  count enable (gated by prescaler)
- up_down  in  1  1 = count up, 0 = count down
- mode  in  1  0 = WRAP, 1 = SATURATE
- load  in  1  synchronous parallel load
- load_value  in  WIDTH  value loaded when load = 1
- count  out  WIDTH  current count
- terminal  out  1  combinational: (up_down & count==MAX_VAL) | (~up_down & count==0)
- wrap_pulse  out  1  registered one-cycle pulse when count wrapped
- sat  out  1  registered level: count is held at a bound in SATURATE mode

## Operation
- Priority per edge: reset > clear > load > step > hold.
- reset low (async): count=0, prescaler=0, wrap_pulse=0, sat=0.
- clear=1: count=0, prescaler=0, wrap_pulse=0, sat=0.
- load=1: count = min(load_value, MAX_VAL), prescaler=0, wrap_pulse=0, sat=0.
- Prescaler: advances only when enable=1; tick = enable & (prescaler==PRESCALE-1), then prescaler returns to 0. With enable=0, prescaler holds. PRESCALE=1: tick = enable.
- Step (tick=1, no clear/load):
  - Up, count<MAX_VAL: count+1, sat=0.
  - Up, count==MAX_VAL, WRAP: count=0, wrap_pulse=1.
  - Up, count==MAX_VAL, SATURATE: count holds, sat=1.
  - Down, count>0: count-1, sat=0.
  - Down, count==0, WRAP: count=MAX_VAL, wrap_pulse=1.
  - Down, count==0, SATURATE: count holds, sat=1.
- wrap_pulse is 0 on every edge without a wrap.
- sat clears on any step that moves count, and on clear or load.
- sat holds when tick=0.
- Arithmetic is done in WIDTH bits; no overflow is possible because bounds are checked before increment/decrement.
- Changing up_down or mode takes effect at the next step; no state is flushed.
- Cascading: next stage enable = enable & terminal for lower stages with PRESCALE=1.

## Timing
- Latency: count reflects a step, load or clear one clock after the qualifying edge inputs.
- terminal is combinational from count and up_down, with no register delay, so it is valid in the same cycle for cascade gating.
- wrap_pulse and sat are valid in the same cycle that count shows the wrapped/held value.
- Reset deassertion mid-operation: counting resumes from 0 with a fresh prescaler phase.
- Reset assertion is immediate and independent of clock.
- With PRESCALE=N and enable held high, count steps once every N clocks; first step occurs N clocks after enable rises from a zero prescaler.

## Structure
- Package counter_pkg holds:
  - the mode type (COUNT_WRAP=1'b0, COUNT_SAT=1'b1);
  - direction constants (DIR_DOWN=0, DIR_UP=1).
- Sub-module count_prescaler(PRESCALE):
  - inputs: clock, reset, clear (driven by clear|load), enable;
  - output: tick;
  - trivial pass-through when PRESCALE=1.
- Top holds the count register, step logic and output flags.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, PRESCALE=1 unless stated.
- Reset low for 2 cycles mid-count at 5 -> count=0, wrap_pulse=0, sat=0 immediately; release, enable=1, up -> 1,2,3 on successive edges.
- Up, WRAP, from 7 -> 8,9,0,1; terminal=1 only while count=9; wrap_pulse=1 only in the cycle count=0.
- Down, SATURATE, load 2 -> 1,0,0,0; sat=1 from the second 0 onward; switch to up -> 1 with sat=0.
- load_value=15 -> count=9 (clamped); simultaneous clear=1 and load=1 -> count=0; load with enable=1 -> loaded value wins over the step.
- PRESCALE=3, enable high from count 0 -> count steps to 1,2,3 at clocks 3,6,9; enable low for 2 cycles between ticks -> step delayed by exactly 2 clocks.
- Two instances cascaded (low enable=1, high enable=terminal_low) -> after 100 enabled clocks the high:low counts read 0:0 with exactly one high-stage wrap_pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter library.
package counter_pkg;

    typedef enum logic {
        COUNT_WRAP = 1'b0,
        COUNT_SAT  = 1'b1
    } count_mode_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles.
module count_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("count_prescaler: PRESCALE must be >= 1");
    end

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // With PRESCALE=1 the phase is constant zero, so tick reduces to enable.
    assign tick = enable & (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (enable) begin
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule : count_prescaler

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with wrap/saturate, load, clear and prescaled enable.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter longint unsigned  MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned      PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap_pulse,
    output logic             sat
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be 1..32");
    end
    if (MAX_VAL == 0 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("mod_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear | load),
        .enable (enable),
        .tick   (tick)
    );

    // Bounds are checked before +/-1, so WIDTH-bit arithmetic never overflows.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (load) begin
            count_d = (load_value > MAX_C) ? MAX_C : load_value;
            sat_d   = 1'b0;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (count_q != MAX_C) begin
                    count_d = count_q + WIDTH'(1);
                    sat_d   = 1'b0;
                end else if (mode == COUNT_SAT) begin
                    sat_d   = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                    sat_d   = 1'b0;
                end else if (mode == COUNT_SAT) begin
                    sat_d   = 1'b1;
                end else begin
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    // Unregistered so a following stage can gate its enable in the same cycle.
    assign terminal   = (up_down == DIR_UP) ? (count_q == MAX_C) : (count_q == '0);
    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign sat        = sat_q;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: directed vectors, queued expectations, decoupled monitor.
module tb_mod_updown_counter;

    typedef struct {
        int    id;
        int    cnt;
        bit    w;
        bit    s;
        bit    t;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   hi_wraps = 0;
    event sample_ev;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       m_clr = 0, m_ld = 0, m_en = 0, m_ud = 0, m_md = 0;
    logic [3:0] m_lv = '0;
    logic [3:0] m_cnt;
    logic       m_term, m_wrap, m_sat;

    logic       p_en = 0;
    logic [3:0] p_cnt;
    logic       p_term, p_wrap, p_sat;

    logic       cas_en = 0;
    logic       c_hi_en;
    logic [3:0] c_lo_cnt, c_hi_cnt;
    logic       c_lo_term, c_lo_wrap, c_lo_sat;
    logic       c_hi_term, c_hi_wrap, c_hi_sat;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut (
        .clock(clk), .reset(rst_n), .clear(m_clr), .enable(m_en), .up_down(m_ud),
        .mode(m_md), .load(m_ld), .load_value(m_lv), .count(m_cnt),
        .terminal(m_term), .wrap_pulse(m_wrap), .sat(m_sat)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_p (
        .clock(clk), .reset(rst_n), .clear(1'b0), .enable(p_en), .up_down(1'b1),
        .mode(1'b0), .load(1'b0), .load_value(4'd0), .count(p_cnt),
        .terminal(p_term), .wrap_pulse(p_wrap), .sat(p_sat)
    );

    assign c_hi_en = cas_en & c_lo_term;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_lo (
        .clock(clk), .reset(rst_n), .clear(1'b0), .enable(cas_en), .up_down(1'b1),
        .mode(1'b0), .load(1'b0), .load_value(4'd0), .count(c_lo_cnt),
        .terminal(c_lo_term), .wrap_pulse(c_lo_wrap), .sat(c_lo_sat)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_hi (
        .clock(clk), .reset(rst_n), .clear(1'b0), .enable(c_hi_en), .up_down(1'b1),
        .mode(1'b0), .load(1'b0), .load_value(4'd0), .count(c_hi_cnt),
        .terminal(c_hi_term), .wrap_pulse(c_hi_wrap), .sat(c_hi_sat)
    );

    always @(negedge clk) if (c_hi_wrap) hi_wraps++;

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    // Monitor: pops every queued expectation just after the edge (or async sample point).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0: begin
                        chk(e.name, "count", int'(m_cnt), e.cnt);
                        chk(e.name, "wrap", int'(m_wrap), int'(e.w));
                        chk(e.name, "sat", int'(m_sat), int'(e.s));
                        chk(e.name, "terminal", int'(m_term), int'(e.t));
                    end
                    1: begin
                        chk(e.name, "count", int'(p_cnt), e.cnt);
                        chk(e.name, "wrap", int'(p_wrap), int'(e.w));
                        chk(e.name, "sat", int'(p_sat), int'(e.s));
                    end
                    2: chk(e.name, "lo_count", int'(c_lo_cnt), e.cnt);
                    3: chk(e.name, "hi_count", int'(c_hi_cnt), e.cnt);
                    default: chk(e.name, "hi_wraps", hi_wraps, e.cnt);
                endcase
            end
        end
    end

    task automatic push(input int id, input int c, input bit w, input bit s, input bit t,
                        input string name);
        exp_t e;
        e.id = id; e.cnt = c; e.w = w; e.s = s; e.t = t; e.name = name;
        sb.push_back(e);
    endtask

    // Drive main DUT for one edge and queue the outputs expected after it.
    task automatic tm(input logic rst, input logic clr, input logic ld, input logic en,
                      input logic ud, input logic md, input logic [3:0] lv,
                      input int ec, input bit ew, input bit es, input bit et, input string name);
        @(negedge clk);
        rst_n = rst; m_clr = clr; m_ld = ld; m_en = en; m_ud = ud; m_md = md; m_lv = lv;
        push(0, ec, ew, es, et, name);
    endtask

    task automatic tp(input logic en, input int ec, input string name);
        @(negedge clk);
        p_en = en;
        push(1, ec, 1'b0, 1'b0, 1'b0, name);
    endtask

    initial begin
        //  rst clr ld en ud md lv     cnt w s t
        tm(0, 0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 1, "reset");
        tm(1, 0, 0, 0, 1, 0, 4'd0,   0, 0, 0, 0, "idle");
        tm(1, 0, 1, 0, 1, 0, 4'd4,   4, 0, 0, 0, "load4");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   5, 0, 0, 0, "up5");
        // Asynchronous reset asserted between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        push(0, 0, 0, 0, 0, "async_rst");
        ->sample_ev;
        tm(0, 0, 0, 1, 1, 0, 4'd0,   0, 0, 0, 0, "rst_hold1");
        tm(0, 0, 0, 1, 1, 0, 4'd0,   0, 0, 0, 0, "rst_hold2");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   1, 0, 0, 0, "resume1");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   2, 0, 0, 0, "resume2");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   3, 0, 0, 0, "resume3");
        // Up, wrap.
        tm(1, 0, 1, 0, 1, 0, 4'd7,   7, 0, 0, 0, "load7");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   8, 0, 0, 0, "wrap_up8");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   9, 0, 0, 1, "wrap_up9");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   0, 1, 0, 0, "wrap_up0");
        tm(1, 0, 0, 1, 1, 0, 4'd0,   1, 0, 0, 0, "wrap_up1");
        // Down, saturate.
        tm(1, 0, 1, 0, 0, 1, 4'd2,   2, 0, 0, 0, "load2");
        tm(1, 0, 0, 1, 0, 1, 4'd0,   1, 0, 0, 0, "sat_dn1");
        tm(1, 0, 0, 1, 0, 1, 4'd0,   0, 0, 0, 1, "sat_dn0");
        tm(1, 0, 0, 1, 0, 1, 4'd0,   0, 0, 1, 1, "sat_dn0b");
        tm(1, 0, 0, 1, 0, 1, 4'd0,   0, 0, 1, 1, "sat_dn0c");
        tm(1, 0, 0, 1, 1, 1, 4'd0,   1, 0, 0, 0, "sat_up1");
        // Load clamp and priority.
        tm(1, 0, 1, 0, 1, 0, 4'd15,  9, 0, 0, 1, "clamp");
        tm(1, 1, 1, 0, 1, 0, 4'd3,   0, 0, 0, 0, "clr_over_ld");
        tm(1, 0, 1, 1, 1, 0, 4'd4,   4, 0, 0, 0, "ld_over_step");
        tm(1, 1, 0, 1, 1, 0, 4'd0,   0, 0, 0, 0, "clr_over_step");
        // Down wrap, saturate hold with enable low, move clears sat.
        tm(1, 0, 0, 1, 0, 0, 4'd0,   9, 1, 0, 0, "wrap_dn9");
        tm(1, 0, 0, 1, 1, 1, 4'd0,   9, 0, 1, 1, "sat_up9");
        tm(1, 0, 0, 0, 1, 1, 4'd0,   9, 0, 1, 1, "sat_hold");
        tm(1, 0, 0, 1, 0, 1, 4'd0,   8, 0, 0, 0, "sat_dn8");
        tm(1, 0, 1, 0, 0, 1, 4'd9,   9, 0, 0, 0, "ld_clr_sat");
        tm(1, 0, 0, 0, 0, 0, 4'd0,   9, 0, 0, 0, "idle_end");

        // Prescale 3: steps every third enabled clock; enable gaps delay the step.
        tp(1, 0, "ps_c1");
        tp(1, 0, "ps_c2");
        tp(1, 1, "ps_c3");
        tp(1, 1, "ps_c4");
        tp(1, 1, "ps_c5");
        tp(1, 2, "ps_c6");
        tp(1, 2, "ps_c7");
        tp(0, 2, "ps_gap1");
        tp(0, 2, "ps_gap2");
        tp(1, 2, "ps_c10");
        tp(1, 3, "ps_c11");
        tp(0, 3, "ps_idle");

        // Cascade: 100 enabled clocks bring both decades back to zero with one high wrap.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cas_en = 1'b1;
        end
        @(negedge clk);
        cas_en = 1'b0;
        push(2, 0, 0, 0, 0, "cascade");
        push(3, 0, 0, 0, 0, "cascade");
        push(4, 1, 0, 0, 0, "cascade");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mod_updown_counter
